// File: rtl/trap_if.sv
// Bundle between the core (decoder, timer, CSR file, PC mux) and the trap sequencer.
// The core side is the master; the sequencer is the slave.
interface trap_if;
  logic [31:0] pc;
  logic        nmi;
  logic        ebreak;
  logic        ecall;
  logic        tmr_irq;
  logic        ext_int;
  logic        en_global;
  logic        en_ecall;
  logic        en_int;
  logic        en_tmr;
  logic        mret;
  logic [31:0] mepc_rdata;
  logic        mepc_we;
  logic [31:0] mepc_wdata;
  logic [2:0]  mcause;
  logic        pc_load;
  logic [31:0] pc_load_addr;
  logic        stall;
  logic        in_trap;

  modport master (
    output pc, nmi, ebreak, ecall, tmr_irq, ext_int,
           en_global, en_ecall, en_int, en_tmr, mret, mepc_rdata,
    input  mepc_we, mepc_wdata, mcause, pc_load, pc_load_addr, stall, in_trap
  );

  modport slave (
    input  pc, nmi, ebreak, ecall, tmr_irq, ext_int,
           en_global, en_ecall, en_int, en_tmr, mret, mepc_rdata,
    output mepc_we, mepc_wdata, mcause, pc_load, pc_load_addr, stall, in_trap
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/exit controller: latches trap sources, arbitrates by fixed priority,
// then sequences save-mepc, redirect-to-vector, handler and mret return.
module trap_sequencer #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0004,
  parameter logic [31:0] CODE_BASE = 32'h0000_0100
) (
  input logic clk,
  input logic rst,
  trap_if.slave tif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_REDIRECT,
    S_HANDLER,
    S_RETURN
  } state_e;

  localparam logic [2:0] C_NMI = 3'd0;
  localparam logic [2:0] C_BRK = 3'd1;
  localparam logic [2:0] C_ECL = 3'd2;
  localparam logic [2:0] C_TMR = 3'd3;
  localparam logic [2:0] C_EXT = 3'd4;

  state_e      state_q;
  logic [3:0]  pend_q;   // bit index = cause code for NMI, EBREAK, ECALL, TIMER
  logic [3:0]  pend_d;
  logic        nmi_q;
  logic [2:0]  mcause_q;

  logic        win_valid;
  logic [2:0]  win_cause;
  logic        take;
  logic [3:0]  set_v;
  logic [3:0]  clr_v;
  logic [31:0] vector;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    win_valid = 1'b0;
    win_cause = C_NMI;
    if (pend_q[0]) begin
      win_valid = 1'b1;
      win_cause = C_NMI;
    end else if (tif.en_global) begin
      if (tif.en_ecall && pend_q[1]) begin
        win_valid = 1'b1;
        win_cause = C_BRK;
      end else if (tif.en_ecall && pend_q[2]) begin
        win_valid = 1'b1;
        win_cause = C_ECL;
      end else if (tif.en_tmr && pend_q[3]) begin
        win_valid = 1'b1;
        win_cause = C_TMR;
      end else if (tif.en_int && tif.ext_int) begin
        win_valid = 1'b1;
        win_cause = C_EXT;
      end
    end
  end

  assign take = win_valid && (state_q == S_IDLE) && (tif.pc >= CODE_BASE);

  // A new request in the same cycle as its take keeps the bit set.
  always_comb begin
    set_v = {tif.tmr_irq, tif.ecall, tif.ebreak, tif.nmi & ~nmi_q};
    clr_v = 4'b0000;
    if (take && (win_cause != C_EXT)) begin
      clr_v[win_cause[1:0]] = 1'b1;
    end
    pend_d = set_v | (pend_q & ~clr_v);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pend_q   <= 4'b0000;
      nmi_q    <= 1'b0;
      mcause_q <= 3'd0;
    end else begin
      pend_q <= pend_d;
      nmi_q  <= tif.nmi;
      unique case (state_q)
        S_IDLE: begin
          if (take) begin
            mcause_q <= win_cause;
            state_q  <= S_SAVE;
          end
        end
        S_SAVE:     state_q <= S_REDIRECT;
        S_REDIRECT: state_q <= S_HANDLER;
        S_HANDLER: begin
          if (tif.mret) state_q <= S_RETURN;
        end
        S_RETURN:   state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  assign vector = VEC_BASE + {27'b0, mcause_q, 2'b00};

  assign tif.stall        = (state_q == S_SAVE) || (state_q == S_REDIRECT);
  assign tif.mepc_we      = (state_q == S_SAVE);
  assign tif.mepc_wdata   = (state_q == S_SAVE) ? tif.pc : 32'h0;
  assign tif.pc_load      = (state_q == S_REDIRECT) || (state_q == S_RETURN);
  assign tif.pc_load_addr = (state_q == S_REDIRECT) ? vector :
                            (state_q == S_RETURN)   ? tif.mepc_rdata : 32'h0;
  assign tif.in_trap      = (state_q == S_HANDLER);
  assign tif.mcause       = mcause_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table, directed multi-cycle
// sequences and randomized traffic against a cycle-level reference model.
module tb_trap_sequencer;

  localparam logic [31:0] VEC_BASE  = 32'h0000_0004;
  localparam logic [31:0] CODE_BASE = 32'h0000_0100;

  logic clk;
  logic rst;
  trap_if tif ();

  trap_sequencer #(.VEC_BASE(VEC_BASE), .CODE_BASE(CODE_BASE)) dut (
    .clk (clk),
    .rst (rst),
    .tif (tif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending requests per cause, and a step count through the
  // trap sequence (0 none, 1 save, 2 redirect, 3 handler, 4 return).
  bit [3:0] m_pend;
  bit       m_nmi_prev;
  int       m_step;
  int       m_cause;

  function automatic bit m_eligible(input int c);
    case (c)
      0:       return m_pend[0];
      1, 2:    return tif.en_global && tif.en_ecall && m_pend[c];
      3:       return tif.en_global && tif.en_tmr && m_pend[3];
      default: return tif.en_global && tif.en_int && tif.ext_int;
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_nmi_prev = 0; m_step = 0; m_cause = 0;
  endtask

  task automatic model_edge();
    int w;
    bit [3:0] raise;
    w = -1;
    if (m_step == 0 && tif.pc >= CODE_BASE) begin
      for (int c = 4; c >= 0; c--) if (m_eligible(c)) w = c;
    end
    raise = {tif.tmr_irq, tif.ecall, tif.ebreak, tif.nmi && !m_nmi_prev};
    for (int c = 0; c < 4; c++) m_pend[c] = raise[c] || (m_pend[c] && (w != c));
    m_nmi_prev = tif.nmi;
    if (m_step == 0) begin
      if (w >= 0) begin m_step = 1; m_cause = w; end
    end else if (m_step == 3) begin
      if (tif.mret) m_step = 4;
    end else begin
      m_step = (m_step + 1) % 5;
    end
  endtask

  task automatic compare_model(input string tag);
    logic [31:0] e_addr;
    e_addr = (m_step == 2) ? VEC_BASE + 32'(m_cause) * 4 :
             (m_step == 4) ? tif.mepc_rdata : 32'h0;
    check({tag, ".stall"},   32'(tif.stall),   32'(m_step == 1 || m_step == 2));
    check({tag, ".we"},      32'(tif.mepc_we), 32'(m_step == 1));
    check({tag, ".wdata"},   tif.mepc_wdata,   (m_step == 1) ? tif.pc : 32'h0);
    check({tag, ".load"},    32'(tif.pc_load), 32'(m_step == 2 || m_step == 4));
    check({tag, ".addr"},    tif.pc_load_addr, e_addr);
    check({tag, ".in_trap"}, 32'(tif.in_trap), 32'(m_step == 3));
    check({tag, ".mcause"},  32'(tif.mcause),  32'(m_cause));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_model(tag);
  endtask

  task automatic clear_inputs();
    tif.pc = 32'h0; tif.nmi = 0; tif.ebreak = 0; tif.ecall = 0; tif.tmr_irq = 0;
    tif.ext_int = 0; tif.en_global = 0; tif.en_ecall = 0; tif.en_int = 0;
    tif.en_tmr = 0; tif.mret = 0; tif.mepc_rdata = 32'h0;
  endtask

  task automatic enable_all();
    tif.en_global = 1; tif.en_ecall = 1; tif.en_int = 1; tif.en_tmr = 1;
  endtask

  task automatic wait_in_trap(input string tag);
    int n;
    n = 0;
    while (!tif.in_trap && n < 20) begin tick(tag); n++; end
    check({tag, ".reached_handler"}, 32'(tif.in_trap), 32'd1);
  endtask

  task automatic do_mret(input logic [31:0] ret_pc);
    tif.mret = 1; tif.mepc_rdata = ret_pc;
    tick("mret");
    check("mret.load", 32'(tif.pc_load), 32'd1);
    check("mret.addr", tif.pc_load_addr, ret_pc);
    tif.mret = 0;
  endtask

  task automatic apply_reset();
    rst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        tmr;
    logic        brk;
    logic        mret;
    logic [31:0] rdata;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic        e_load;
    logic [31:0] e_addr;
    logic        e_in;
    logic [2:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 0;
    model_reset();
    #1;
    check("reset.stall", 32'(tif.stall), 32'd0);
    check("reset.load",  32'(tif.pc_load), 32'd0);
    apply_reset();

    // Idle after reset: all outputs 0 for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick("idle");
      check("idle.any_out",
            32'({tif.stall, tif.mepc_we, tif.pc_load, tif.in_trap}) | tif.mepc_wdata |
            tif.pc_load_addr | 32'(tif.mcause), 32'd0);
    end

    // Timer trap, then EBREAK deferred in the handler region.
    //             pc       tmr brk mret rdata    we wdata    stl ld addr     in cause
    vecs.push_back('{32'h200, 1, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd0});
    vecs.push_back('{32'h200, 0, 0, 0, 32'h0,     1, 32'h200, 1, 0, 32'h0,   0, 3'd3});
    vecs.push_back('{32'h200, 0, 0, 0, 32'h0,     0, 32'h0,   1, 1, 32'h10,  0, 3'd3});
    vecs.push_back('{32'h10,  0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   1, 3'd3});
    vecs.push_back('{32'h10,  0, 0, 1, 32'h200,   0, 32'h0,   0, 1, 32'h200, 0, 3'd3});
    vecs.push_back('{32'h200, 0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd3});
    vecs.push_back('{32'h80,  0, 1, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd3});
    vecs.push_back('{32'h80,  0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd3});
    vecs.push_back('{32'hFC,  0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd3});
    vecs.push_back('{32'h100, 0, 0, 0, 32'h0,     1, 32'h100, 1, 0, 32'h0,   0, 3'd1});
    vecs.push_back('{32'h100, 0, 0, 0, 32'h0,     0, 32'h0,   1, 1, 32'h8,   0, 3'd1});
    vecs.push_back('{32'h8,   0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   1, 3'd1});
    vecs.push_back('{32'h8,   0, 0, 1, 32'h104,   0, 32'h0,   0, 1, 32'h104, 0, 3'd1});
    vecs.push_back('{32'h104, 0, 0, 0, 32'h0,     0, 32'h0,   0, 0, 32'h0,   0, 3'd1});

    enable_all();
    foreach (vecs[i]) begin
      tif.pc = vecs[i].pc; tif.tmr_irq = vecs[i].tmr; tif.ebreak = vecs[i].brk;
      tif.mret = vecs[i].mret; tif.mepc_rdata = vecs[i].rdata;
      tick("vec");
      check($sformatf("vec%0d.we", i),      32'(tif.mepc_we),  32'(vecs[i].e_we));
      check($sformatf("vec%0d.wdata", i),   tif.mepc_wdata,    vecs[i].e_wdata);
      check($sformatf("vec%0d.stall", i),   32'(tif.stall),    32'(vecs[i].e_stall));
      check($sformatf("vec%0d.load", i),    32'(tif.pc_load),  32'(vecs[i].e_load));
      check($sformatf("vec%0d.addr", i),    tif.pc_load_addr,  vecs[i].e_addr);
      check($sformatf("vec%0d.in_trap", i), 32'(tif.in_trap),  32'(vecs[i].e_in));
      check($sformatf("vec%0d.mcause", i),  32'(tif.mcause),   32'(vecs[i].e_cause));
    end
    clear_inputs();
    enable_all();
    tif.pc = 32'h200;
    tick("gap");

    // Priority: NMI, ECALL and timer together are taken as 0, 2, 3.
    tif.nmi = 1; tif.ecall = 1; tif.tmr_irq = 1;
    tick("prio");
    tif.ecall = 0; tif.tmr_irq = 0;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] exp_c;
      exp_c = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : 3'd3;
      wait_in_trap("prio");
      check($sformatf("prio%0d.mcause", k), 32'(tif.mcause), 32'(exp_c));
      do_mret(32'h200);
      tick("prio_gap");
      check($sformatf("prio%0d.idle_gap", k), 32'({tif.stall, tif.pc_load, tif.in_trap}), 32'd0);
    end
    tif.nmi = 0;
    tick("prio_end");

    // Masking: timer waits for en_global, NMI ignores it.
    tif.en_global = 0;
    tif.tmr_irq = 1;
    tick("mask");
    tif.tmr_irq = 0;
    for (int i = 0; i < 5; i++) begin
      tick("mask");
      check("mask.no_stall", 32'(tif.stall), 32'd0);
    end
    tif.en_global = 1;
    tick("unmask");
    check("unmask.we", 32'(tif.mepc_we), 32'd1);
    check("unmask.mcause", 32'(tif.mcause), 32'd3);
    wait_in_trap("unmask");
    do_mret(32'h200);
    tif.en_global = 0;
    tif.nmi = 1;
    wait_in_trap("nmi_masked");
    check("nmi_masked.mcause", 32'(tif.mcause), 32'd0);
    tif.nmi = 0;
    do_mret(32'h204);
    tick("mask_end");

    // Reset during REDIRECT drops pc_load and clears the still-pending timer.
    enable_all();
    tif.ebreak = 1; tif.tmr_irq = 1;
    tick("rst_seq");
    tif.ebreak = 0; tif.tmr_irq = 0;
    tick("rst_seq");
    tick("rst_seq");
    check("rst_seq.redirect", 32'(tif.pc_load), 32'd1);
    #2 rst = 0;
    model_reset();
    #1;
    check("rst_mid.load",   32'(tif.pc_load), 32'd0);
    check("rst_mid.addr",   tif.pc_load_addr, 32'd0);
    check("rst_mid.stall",  32'(tif.stall),   32'd0);
    check("rst_mid.mcause", 32'(tif.mcause),  32'd0);
    @(posedge clk);
    #2 rst = 1;
    for (int i = 0; i < 10; i++) begin
      tick("post_rst");
      check("post_rst.no_trap", 32'({tif.stall, tif.in_trap}), 32'd0);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       tif.pc = 32'h80;
        1:       tif.pc = 32'h100;
        default: tif.pc = 32'h100 + 32'($urandom_range(0, 32'hFFFF));
      endcase
      tif.ebreak     = ($urandom_range(0, 15) == 0);
      tif.ecall      = ($urandom_range(0, 15) == 0);
      tif.tmr_irq    = ($urandom_range(0, 15) == 0);
      tif.ext_int    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) tif.nmi = ~tif.nmi;
      tif.mret       = ($urandom_range(0, 3) == 0);
      tif.mepc_rdata = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        tif.en_global = 1'($urandom); tif.en_ecall = 1'($urandom);
        tif.en_int    = 1'($urandom); tif.en_tmr   = 1'($urandom);
      end
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap entry/exit controller for the RV32IC core's interrupt path. It latches pending trap sources (NMI, EBREAK, ECALL, machine timer, external interrupt) and arbitrates them by fixed priority under the MIE-style enables. It then sequences entry: stall, save `mepc`, redirect the PC to the cause's vector, and on `mret` restores the PC. It sits between the decoder/timer sources, the CSR register file (`mepc` write/read port) and the PC mux.

## Interface
Parameters:
- `VEC_BASE`, 32'h0000_0004: address of the cause-0 handler vector.
- `CODE_BASE`, 32'h0000_0100: lowest user-code address; traps are deferred while `pc < CODE_BASE`, i.e. while executing in the handler region.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc`  in  32  address of the instruction currently in decode.
- `nmi`  in  1  non-maskable interrupt, rising-edge sensitive.
- `ebreak`, `ecall`  in  1 each  one-cycle decode pulses.
- `tmr_irq`  in  1  timer compare pulse.
- `ext_int`  in  1  external interrupt, level sensitive, not latched.
- `en_global`, `en_ecall`, `en_int`, `en_tmr`  in  1 each  enable bits from `mie[3:0]`.
- `mret`  in  1  one-cycle pulse when decode sees MRET.
- `mepc_rdata`  in  32  current `mepc` value from the CSR file.
- `mepc_we`  out  1  `mepc` write strobe.
- `mepc_wdata`  out  32  value to write to `mepc`.
- `mcause`  out  3  cause of the trap being serviced.
- `pc_load`  out  1  one-cycle PC-mux override.
- `pc_load_addr`  out  32  PC value to load when `pc_load` is high.
- `stall`  out  1  freeze the fetch/decode stages.
- `in_trap`  out  1  high while the handler executes.

## Operation
- Pending bits `p_nmi`, `p_brk`, `p_ecl`, `p_tmr`:
  - Set on the `nmi` rising edge (the previous `nmi` value is registered), and on `ebreak`, `ecall` or `tmr_irq` high at a clock edge.
  - Cleared only when that cause is taken, or by reset.
  - A set and a take in the same cycle leaves the bit set (set wins).
- Enable gating: eligible = `p_nmi` | (`en_global` & ((`en_ecall` & (`p_brk`|`p_ecl`)) | (`en_tmr` & `p_tmr`) | (`en_int` & `ext_int`))).
- Priority and `mcause` code: NMI=0 > EBREAK=1 > ECALL=2 > TIMER=3 > EXT=4.
- Vector: `VEC_BASE + {27'b0, cause, 2'b00}`, modulo 2^32.
- FSM states IDLE, SAVE, REDIRECT, HANDLER, RETURN. Encoding is free.
  - IDLE: if eligible and `pc >= CODE_BASE`, latch the winning cause into `mcause`, clear its pending bit, and go to SAVE. Otherwise stay in IDLE.
  - SAVE: `stall`=1, `mepc_we`=1, `mepc_wdata`=`pc`. Go to REDIRECT.
  - REDIRECT: `stall`=1, `pc_load`=1, `pc_load_addr`=vector. Go to HANDLER.
  - HANDLER: `in_trap`=1. There is no nesting; new requests stay pending (including NMI). On `mret`, go to RETURN.
  - RETURN: `pc_load`=1, `pc_load_addr`=`mepc_rdata`. Go to IDLE.
- `mret` outside HANDLER is ignored.
- Outputs are decoded from the registered state. `mepc_wdata` and `pc_load_addr` are 0 when their strobe is low.

## Timing
- Reset values: state IDLE, all pending bits 0, registered `nmi`=0, `mcause`=0. All outputs are 0.
- Reset assertion takes effect immediately, mid-sequence included; any pending `pc_load` or `mepc_we` is dropped.
- Latency, for a source pulse at edge N:
  - Pending is set at N.
  - IDLE→SAVE at N+1 (`mepc_we` high during cycle N+1).
  - REDIRECT during N+2; HANDLER from N+3.
- Level `ext_int` seen in IDLE at edge N gives SAVE from edge N.
- RETURN follows the `mret` edge by one cycle; `pc_load` is high for exactly one cycle.
- `stall` is high for exactly two cycles per trap entry.
- If sources arrive simultaneously, one trap is taken at a time in priority order. The others are taken after the subsequent RETURN, with at least one IDLE cycle between traps.
- Disabled sources stay pending and fire once they are enabled. The exception is `ext_int`, which is never latched.

## Test plan
1. Reset then idle: release `rst` with all inputs low → all outputs 0 for 20 cycles.
2. Timer trap: `en_global`=1, `en_tmr`=1, `pc`=0x200, pulse `tmr_irq`.
   - Two cycles later `mepc_we`=1 with `mepc_wdata`=0x200.
   - Next cycle `pc_load_addr`=0x10 (defaults), `mcause`=3.
   - Drive `mret` with `mepc_rdata`=0x200 → `pc_load_addr`=0x200.
3. Priority: pulse `ecall` and `tmr_irq` together with `nmi` rising, all enabled.
   - Traps taken in order with `mcause` 0, 2, 3, each after an `mret`.
4. Masking:
   - `en_global`=0 with `tmr_irq` pulsed → no trap.
   - Set `en_global`=1 → trap taken 2 cycles later.
   - `nmi` with `en_global`=0 → still taken.
5. Deferral: pulse `ebreak` with `pc`=0x80 → no SAVE. Move `pc` to 0x100 → SAVE next cycle, `mcause`=1, vector 0x8.
6. Reset mid-sequence: assert `rst` during REDIRECT → `pc_load` drops immediately and all pending bits clear. After release, no trap is taken.
